// File: rtl/div_seq.sv
// Sequential restoring divider for the EX stage: signed (DIV) and unsigned (DIVU),
// one quotient bit per cycle, result returned as {remainder, quotient}.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  localparam logic [5:0] CNT_LAST = 6'(DATA_W);

  state_t              r_state;
  logic [5:0]          r_cnt;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_div;
  logic                r_neg_q;
  logic                r_neg_r;

  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;

  function automatic logic [DATA_W-1:0] f_abs(input logic sg, input logic [DATA_W-1:0] v);
    return (sg && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] f_neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Trial subtraction; the borrow out of the extra top bit marks a negative result.
  assign w_shift = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_qbit  = ~w_diff[DATA_W];

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (r_state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            r_neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg_r <= signed_div_i & opdata1_i[DATA_W-1];
            r_dvd   <= f_abs(signed_div_i, opdata1_i);
            r_div   <= f_abs(signed_div_i, opdata2_i);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          r_dvd   <= '0;
          r_rem   <= '0;
          r_state <= END;
        end
        ON: begin
          if (annul_i) begin
            r_dvd   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= FREE;
          end else if (r_cnt != CNT_LAST) begin
            r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
            r_rem <= w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_dvd   <= f_neg_if(r_neg_q, r_dvd);
            r_rem   <= f_neg_if(r_neg_r, r_rem);
            r_state <= END;
          end
        end
        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {r_rem, r_dvd};
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
            r_state  <= FREE;
          end
        end
        default: r_state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by zero,
// boundary operands, annul, mid-divide reset and operand changes after start.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_err = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges (first edge = 0) until ready_o; optionally scrambles inputs each cycle.
  task automatic wait_ready(input logic scramble, input int lat, output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n = i;
      if (ready_o) break;
      if (i == lat - 1) check("stall_busy", {63'd0, stallreq_o}, 64'd1);
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
    if (!ready_o) n = 999;
  endtask

  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input logic scramble);
    int n;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(scramble, lat, n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_rdy"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    logic seen_rdy;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {63'd0, ready_o}, 64'd0);
    check("rst_res", result_o, 64'd0);
    check("rst_stall_idle", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    check("rst_stall_req", {63'd0, stallreq_o}, 64'd1);
    check("rst_over_start", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0;
    rst = 1'b0;

    do_div("u100_7",   1'b0, 32'd100,       32'd7,         {32'h2, 32'hE},               34, 1'b0);
    do_div("s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 1'b0);
    do_div("s_7_m2",   1'b1, 32'd7,         32'hFFFFFFFE,  {32'h1, 32'hFFFFFFFD},        34, 1'b0);
    do_div("s_m100_m7",1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE, 32'hE},        34, 1'b0);
    do_div("u_fff9_2", 1'b0, 32'hFFFFFFF9,  32'd2,         {32'h1, 32'h7FFFFFFC},        34, 1'b0);
    do_div("div0",     1'b0, 32'd5,         32'd0,         64'd0,                        2,  1'b0);
    do_div("s_min_m1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},        34, 1'b0);
    do_div("u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0, 32'hFFFFFFFF},        34, 1'b0);
    do_div("u_3_max",  1'b0, 32'd3,         32'hFFFFFFFF,  {32'h3, 32'h0},               34, 1'b0);
    do_div("scramble", 1'b0, 32'd1000,      32'd10,        {32'h0, 32'h64},              34, 1'b1);

    // Annul during ON cycle 10, then an immediate new start.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    seen_rdy = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); #1;
      seen_rdy |= ready_o;
    end
    annul_i = 1'b1;
    #1;
    check("annul_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    seen_rdy |= ready_o;
    check("annul_res", result_o, 64'd0);
    annul_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen_rdy |= ready_o;
    end
    check("annul_no_rdy", {63'd0, seen_rdy}, 64'd0);
    wait_ready(1'b0, 30, n);
    check("after_annul_lat", 64'(n + 4), 64'd34);
    check("after_annul_res", result_o, {32'h0, 32'h3});
    start_i = 1'b0;
    @(posedge clk); #1;

    // Reset during ON cycle 20.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rdy", {63'd0, ready_o}, 64'd0);
    check("midrst_res", result_o, 64'd0);
    check("midrst_stall", {63'd0, stallreq_o}, 64'd1);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_rdy", {63'd0, ready_o}, 64'd0);
    do_div("post_rst", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
